byte_striping: RTL and testbench
================================

// Module: byte_striping
// PURPOSE
//  TX byte striper feeding the per-lane parallel_serial_cond serializers (one per lane).
//  - Buffers an incoming byte stream in a FIFO.
//  - Every symbol period (SYM_CYCLES clocks), distributes bytes round-robin across the lanes: byte k -> lane k mod LANES.
//  - Lanes with no data carry the idle symbol with lane_valid low.
// PARAMETERS
//  LANES      4      number of lanes / serializers driven
//  DEPTH      16     FIFO depth in bytes; power of 2, >= 2*LANES
//  SYM_CYCLES 8      clocks per byte on a serial lane (serializer load period)
//  IDLE_SYM   8'hBC  symbol driven on a lane whose lane_valid is low
// PORTS
//  CLK         in   1                    single clock, rising edge
//  RESET       in   1                    asynchronous, active-high reset
//  data_in     in   8                    input byte
//  valid_in    in   1                    data_in valid
//  ready_out   out  1                    FIFO can accept; write occurs on valid_in & ready_out
//  lane_data   out  8*LANES              lane i = bits [8*i+7:8*i]
//  lane_valid  out  LANES                per-lane byte valid
//  sym_start   out  1                    high during the first cycle of each symbol period
//  fifo_count  out  $clog2(DEPTH)+1      bytes currently buffered
// BEHAVIOUR
//  Reset (async, any time, including mid-stripe):
//   - sym_cnt=0; FIFO empty (fifo_count=0); ready_out=1.
//   - lane_data={LANES{IDLE_SYM}}; lane_valid=0; sym_start=1 in the first cycle after release.
//   - Discards buffered bytes; no partial stripe survives.
//  Symbol counter: sym_cnt counts 0..SYM_CYCLES-1, wraps; sym_start = (sym_cnt==0).
//   - Tick edge = rising edge with sym_cnt==SYM_CYCLES-1.
//  Lane outputs are registers; they change only at tick edges and hold for exactly SYM_CYCLES clocks.
//  FIFO: ready_out = (fifo_count != DEPTH).
//   - Write and pop on the same edge are legal: count_next = count + wr - popped.
//   - Write when full is impossible (ready low); valid_in with ready low is ignored, nothing lost.
//  Dispatch at tick edge, using pre-edge fifo_count (a byte written on the tick edge is not eligible):
//   - count >= LANES: pop LANES bytes in order; lane i <= fifo[rd+i]; lane_valid all 1.
//   - count < LANES: see CONFIGURATION.
//   - Pointers wrap mod DEPTH; stripe may straddle the wrap point.
//  Latency: the LANES-th byte of a stripe written at edge E appears on lanes at the first tick edge after E.
//   - Minimum 1 clock, maximum SYM_CYCLES clocks.
//  Order: bytes never reordered; lane 0 always carries the oldest byte of a stripe.
// CONFIGURATION
//  BYTE_STRIPING_PAD_EN defined:
//   - At tick with 0 < count < LANES: pop all count bytes into lanes 0..count-1 (lane_valid=1).
//   - Lanes count..LANES-1 get IDLE_SYM with lane_valid=0.
//  BYTE_STRIPING_PAD_EN undefined:
//   - Partial stripes wait in FIFO until count >= LANES.
//   - At a tick with count < LANES, all lanes <= IDLE_SYM, lane_valid=0.
//  Either build: count==0 at tick -> all lanes idle.
// STRUCTURE
//  Shared include pcie_defs.vh: IDLE_SYM (K28.5 = 8'hBC), SYM_CYCLES, default LANES.
//   - Same constants used by parallel_serial_cond / serial_parallel_cond.
//  Sub-module byte_fifo:
//   - DEPTH x 8 storage, wr/rd pointers, count.
//   - Multi-read port exposing LANES consecutive entries from rd.
//   - pop_n input (0..LANES).
//  Top level: sym_cnt, dispatch logic, lane registers.
// TESTING
//  1. Reset release, valid_in=0 for 3 symbol periods
//     -> lane_valid=0, lane_data=BCBCBCBC, sym_start every 8th cycle, fifo_count=0.
//  2. Write 8'h01..8'h04 back-to-back, then idle
//     -> next tick: lane0..3 = 01,02,03,04, lane_valid=4'hF, held 8 clocks; next tick all idle.
//  3. Write 01..06 then stop
//     -> stripe 01..04 dispatched.
//     -> PAD_EN: next tick lanes 05,06,BC,BC, valid=4'b0011.
//     -> no PAD_EN: lanes idle, fifo_count=2 until 07,08 written, then 05..08.
//  4. Write continuously every clock with no drain
//     -> fifo_count reaches 16, ready_out=0.
//     -> tick pops 4 (count 12 or 13 with same-edge write).
//     -> byte order across stripes preserved, no byte lost or duplicated.
//  5. Write on the tick edge itself with count=3 pre-edge
//     -> no full stripe dispatched that tick (no PAD_EN); dispatched next tick.
//  6. Assert RESET mid-symbol with lanes valid and fifo_count=9
//     -> immediately lane_valid=0, lanes=BC, fifo_count=0, ready_out=1.
//     -> after release sym_cnt restarts at 0.

Source files
------------

// File: rtl/byte_striping_pkg.sv
// Shared constants for the TX byte striper (K28.5 idle symbol, symbol period, default lane count).
// Also provides a small width helper used by the striper and its FIFO.
package byte_striping_pkg;

  localparam int         LANES_DEF      = 4;
  localparam int         DEPTH_DEF      = 16;
  localparam int         SYM_CYCLES_DEF = 8;
  localparam logic [7:0] IDLE_SYM_DEF   = 8'hBC;  // K28.5

  // Counter width that stays at least 1 bit for degenerate sizes.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/byte_striping_fifo.sv
// Byte FIFO with a multi-read port: exposes LANES consecutive entries starting at the
// read pointer and pops 0..LANES of them per clock. Pointers wrap mod DEPTH (power of 2).
module byte_fifo
  import byte_striping_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int LANES = LANES_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [7:0]                   wr_data,
  input  logic [$clog2(LANES+1)-1:0]   pop_n,
  output logic [8*LANES-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;

  assign full  = (count == CW'(DEPTH));
  assign do_wr = wr_en && !full;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // A write and a pop on the same edge both take effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_ptr + AW'(pop_n);
      count  <= count + CW'(do_wr) - CW'(pop_n);
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < LANES; i++) begin
      rd_data[8*i +: 8] = mem[rd_ptr + AW'(i)];
    end
  end

endmodule

// File: rtl/byte_striping.sv
// TX byte striper: buffers bytes and, once per symbol period, deals LANES bytes round-robin
// onto the lane registers. Optional padding of short stripes: define BYTE_STRIPING_PAD_EN.
module byte_striping
  import byte_striping_pkg::*;
#(
  parameter int         LANES      = LANES_DEF,
  parameter int         DEPTH      = DEPTH_DEF,
  parameter int         SYM_CYCLES = SYM_CYCLES_DEF,
  parameter logic [7:0] IDLE_SYM   = IDLE_SYM_DEF
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [7:0]             data_in,
  input  logic                   valid_in,
  output logic                   ready_out,
  output logic [8*LANES-1:0]     lane_data,
  output logic [LANES-1:0]       lane_valid,
  output logic                   sym_start,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int PW  = $clog2(LANES + 1);
  localparam int SCW = clog2_min1(SYM_CYCLES);

  logic [SCW-1:0]     sym_cnt;
  logic               tick;
  logic               fifo_full;
  logic               wr_en;
  logic [PW-1:0]      pop_n;
  logic [8*LANES-1:0] fifo_rd;
  logic [8*LANES-1:0] lane_data_nxt;
  logic [LANES-1:0]   lane_valid_nxt;

  // Input handshake: a byte is accepted on a rising edge where valid_in && ready_out;
  // valid_in while ready_out is low is simply not taken, the source holds it.
  assign ready_out = !fifo_full;
  assign wr_en     = valid_in && ready_out;

  assign tick      = (sym_cnt == SCW'(SYM_CYCLES - 1));
  assign sym_start = (sym_cnt == '0);

  byte_fifo #(
    .DEPTH (DEPTH),
    .LANES (LANES)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RESET),
    .wr_en   (wr_en),
    .wr_data (data_in),
    .pop_n   (pop_n),
    .rd_data (fifo_rd),
    .count   (fifo_count),
    .full    (fifo_full)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) sym_cnt <= '0;
    else if (tick) sym_cnt <= '0;
    else sym_cnt <= sym_cnt + 1'b1;
  end

  // Dispatch decision uses the pre-edge count, so a byte written on the tick edge waits.
  always_comb begin
    pop_n          = '0;
    lane_data_nxt  = {LANES{IDLE_SYM}};
    lane_valid_nxt = '0;
    if (tick) begin
      if (fifo_count >= CW'(LANES)) begin
        pop_n          = PW'(LANES);
        lane_data_nxt  = fifo_rd;
        lane_valid_nxt = '1;
      end
`ifdef BYTE_STRIPING_PAD_EN
      else begin
        pop_n = PW'(fifo_count);
        for (int i = 0; i < LANES; i++) begin
          if (CW'(i) < fifo_count) begin
            lane_data_nxt[8*i +: 8] = fifo_rd[8*i +: 8];
            lane_valid_nxt[i]       = 1'b1;
          end
        end
      end
`endif
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      lane_data  <= {LANES{IDLE_SYM}};
      lane_valid <= '0;
    end else if (tick) begin
      lane_data  <= lane_data_nxt;
      lane_valid <= lane_valid_nxt;
    end
  end

endmodule

// File: tb/tb_byte_striping.sv
// Bench for byte_striping: hand-derived vector table, directed corner sequences and random
// traffic checked against a queue-based model of the striping rules.
module tb_byte_striping;

  localparam int         LANES      = 4;
  localparam int         DEPTH      = 16;
  localparam int         SYM_CYCLES = 8;
  localparam logic [7:0] IDLE       = 8'hBC;
  localparam logic [31:0] IDLE_W    = 32'hBCBCBCBC;

  logic                   CLK;
  logic                   RESET;
  logic [7:0]             data_in;
  logic                   valid_in;
  logic                   ready_out;
  logic [8*LANES-1:0]     lane_data;
  logic [LANES-1:0]       lane_valid;
  logic                   sym_start;
  logic [$clog2(DEPTH):0] fifo_count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] exp_q[$];
  logic [7:0] m_lane [LANES];
  logic       m_valid [LANES];
  int         edges;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic [3:0]  lv;
    logic [31:0] ld;
    logic [4:0]  cnt;
    logic        ss;
  } vec_t;
  vec_t tbl [16];

  byte_striping dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .lane_data  (lane_data),
    .lane_valid (lane_valid),
    .sym_start  (sym_start),
    .fifo_count (fifo_count)
  );

  // ---------------- clock ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic [3:0] lv,
                              input logic [31:0] ld, input logic [4:0] cnt, input logic ss);
    vec_t r;
    r.v = v; r.d = d; r.lv = lv; r.ld = ld; r.cnt = cnt; r.ss = ss;
    return r;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < LANES; i++) begin
      m_lane[i]  = IDLE;
      m_valid[i] = 1'b0;
    end
    edges = 0;
  endtask

  task automatic check_model();
    logic [31:0] eld;
    logic [3:0]  elv;
    for (int i = 0; i < LANES; i++) begin
      eld[8*i +: 8] = m_lane[i];
      elv[i]        = m_valid[i];
    end
    chk("model_lane_data", lane_data, eld);
    chk("model_lane_valid", 32'(lane_valid), 32'(elv));
    chk("model_fifo_count", 32'(fifo_count), exp_q.size());
    chk("model_ready", 32'(ready_out), 32'(exp_q.size() != DEPTH));
    chk("model_sym_start", 32'(sym_start), 32'((edges % SYM_CYCLES) == 0));
  endtask

  // One clock: drive inputs, advance the model on the edge, compare just after it.
  task automatic step(input logic v, input logic [7:0] d);
    int  pre;
    bit  tick;
    bit  wr;
    valid_in = v;
    data_in  = d;
    @(posedge CLK);
    pre  = exp_q.size();
    tick = (edges % SYM_CYCLES) == SYM_CYCLES - 1;
    wr   = v && (pre != DEPTH);
    if (tick) begin
      for (int i = 0; i < LANES; i++) begin
        m_lane[i]  = IDLE;
        m_valid[i] = 1'b0;
      end
      if (pre >= LANES) begin
        for (int i = 0; i < LANES; i++) begin
          m_lane[i]  = exp_q.pop_front();
          m_valid[i] = 1'b1;
        end
      end
`ifdef BYTE_STRIPING_PAD_EN
      else begin
        for (int i = 0; i < pre; i++) begin
          m_lane[i]  = exp_q.pop_front();
          m_valid[i] = 1'b1;
        end
      end
`endif
    end
    if (wr) exp_q.push_back(d);
    edges++;
    #1;
    check_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  // Reset asserted mid-cycle; outputs must clear without waiting for a clock.
  task automatic do_reset();
    valid_in = 1'b0;
    RESET    = 1'b1;
    #2;
    chk("rst_lane_valid", 32'(lane_valid), 32'h0);
    chk("rst_lane_data", lane_data, IDLE_W);
    chk("rst_fifo_count", 32'(fifo_count), 32'h0);
    chk("rst_ready", 32'(ready_out), 32'h1);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    model_reset();
    #1;
    chk("rst_sym_start", 32'(sym_start), 32'h1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ss_cnt;
    int mode;
    logic [7:0] seq;
    RESET    = 1'b1;
    valid_in = 1'b0;
    data_in  = 8'h00;
    model_reset();

    // Vectors for four bytes striped after reset: written edges 1..4, dispatched at edge 8.
    for (int n = 0; n < 16; n++) tbl[n] = mk(1'b0, 8'h00, 4'h0, IDLE_W, 5'd4, 1'b0);
    tbl[0] = mk(1'b1, 8'h01, 4'h0, IDLE_W, 5'd1, 1'b0);
    tbl[1] = mk(1'b1, 8'h02, 4'h0, IDLE_W, 5'd2, 1'b0);
    tbl[2] = mk(1'b1, 8'h03, 4'h0, IDLE_W, 5'd3, 1'b0);
    tbl[3] = mk(1'b1, 8'h04, 4'h0, IDLE_W, 5'd4, 1'b0);
    tbl[7] = mk(1'b0, 8'h00, 4'hF, 32'h04030201, 5'd0, 1'b1);
    for (int n = 8; n < 15; n++) tbl[n] = mk(1'b0, 8'h00, 4'hF, 32'h04030201, 5'd0, 1'b0);
    tbl[15] = mk(1'b0, 8'h00, 4'h0, IDLE_W, 5'd0, 1'b1);

    // Idle after reset for three symbol periods
    do_reset();
    ss_cnt = 0;
    for (int n = 0; n < 3 * SYM_CYCLES; n++) begin
      step(1'b0, 8'h00);
      if (sym_start) ss_cnt++;
    end
    chk("idle_sym_start_count", ss_cnt, 3);

    // Table: single full stripe
    do_reset();
    for (int n = 0; n < 16; n++) begin
      step(tbl[n].v, tbl[n].d);
      chk("tbl_lane_valid", 32'(lane_valid), 32'(tbl[n].lv));
      chk("tbl_lane_data", lane_data, tbl[n].ld);
      chk("tbl_fifo_count", 32'(fifo_count), 32'(tbl[n].cnt));
      chk("tbl_sym_start", 32'(sym_start), 32'(tbl[n].ss));
    end

    // Six bytes: one full stripe plus a remainder of two
    do_reset();
    for (int b = 1; b <= 6; b++) step(1'b1, 8'(b));
    idle(2);
    chk("t3_stripe1_data", lane_data, 32'h04030201);
    chk("t3_stripe1_count", 32'(fifo_count), 32'd2);
    idle(8);
`ifdef BYTE_STRIPING_PAD_EN
    chk("t3_rem_data", lane_data, 32'hBCBC0605);
    chk("t3_rem_valid", 32'(lane_valid), 32'h3);
    chk("t3_rem_count", 32'(fifo_count), 32'd0);
`else
    chk("t3_rem_data", lane_data, IDLE_W);
    chk("t3_rem_valid", 32'(lane_valid), 32'h0);
    chk("t3_rem_count", 32'(fifo_count), 32'd2);
`endif
    step(1'b1, 8'h07);
    step(1'b1, 8'h08);
    idle(6);
`ifdef BYTE_STRIPING_PAD_EN
    chk("t3_last_data", lane_data, 32'hBCBC0807);
    chk("t3_last_valid", 32'(lane_valid), 32'h3);
`else
    chk("t3_last_data", lane_data, 32'h08070605);
    chk("t3_last_valid", 32'(lane_valid), 32'hF);
`endif
    chk("t3_last_count", 32'(fifo_count), 32'd0);

    // Continuous writes with no extra drain until the FIFO fills
    do_reset();
    seq = 8'h20;
    for (int n = 0; n < 31; n++) begin
      step(1'b1, seq);
      seq++;
    end
    chk("t4_full_count", 32'(fifo_count), 32'd16);
    chk("t4_full_ready", 32'(ready_out), 32'h0);
    step(1'b1, seq);
    chk("t4_after_tick_count", 32'(fifo_count), 32'd12);
    chk("t4_after_tick_ready", 32'(ready_out), 32'h1);
    for (int n = 0; n < 40; n++) begin
      seq++;
      step(1'b1, seq);
    end
    idle(48);

    // Fourth byte written on the tick edge itself
    do_reset();
    step(1'b1, 8'h01);
    step(1'b1, 8'h02);
    step(1'b1, 8'h03);
    idle(4);
    step(1'b1, 8'h04);
`ifdef BYTE_STRIPING_PAD_EN
    chk("t5_tick_valid", 32'(lane_valid), 32'h7);
    chk("t5_tick_data", lane_data, 32'hBC030201);
    chk("t5_tick_count", 32'(fifo_count), 32'd1);
`else
    chk("t5_tick_valid", 32'(lane_valid), 32'h0);
    chk("t5_tick_data", lane_data, IDLE_W);
    chk("t5_tick_count", 32'(fifo_count), 32'd4);
`endif
    idle(8);
`ifdef BYTE_STRIPING_PAD_EN
    chk("t5_next_data", lane_data, 32'hBCBCBC04);
    chk("t5_next_valid", 32'(lane_valid), 32'h1);
`else
    chk("t5_next_data", lane_data, 32'h04030201);
    chk("t5_next_valid", 32'(lane_valid), 32'hF);
`endif

    // Reset mid-symbol with lanes valid and nine bytes buffered
    do_reset();
    for (int b = 0; b < 13; b++) step(1'b1, 8'(8'h10 + b));
    chk("t6_pre_count", 32'(fifo_count), 32'd9);
    chk("t6_pre_data", lane_data, 32'h13121110);
    chk("t6_pre_valid", 32'(lane_valid), 32'hF);
    do_reset();
    idle(SYM_CYCLES + 1);

    // Random traffic with varying write density and one reset in the middle
    for (int n = 0; n < 600; n++) begin
      if (n == 300) do_reset();
      mode = (n / 50) % 3;
      case (mode)
        0:       step($urandom_range(7, 0) == 0, 8'($urandom));
        1:       step($urandom_range(1, 0) == 0, 8'($urandom));
        default: step($urandom_range(15, 0) != 0, 8'($urandom));
      endcase
    end
    idle(4 * SYM_CYCLES);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
